// File: rtl/ingress_rdreq_dispatch_if.sv
// -----------------------------------------------------------------------------
// Shared types and port bundles for ingress_rdreq_dispatch.
//
// ingress_rdreq_pkg : parsed TLP header type and default ingress data width.
// rdreq_in_if       : header stream from the ingress pre-parser
//                     (data, keep, meta, valid -> ; <- rdy).
// rd_req_out_if     : decoded request stream toward action/completion logic
//                     (valid, tdest, cpl_ctx, err -> ; <- rdy).
// master drives the payload and valid, slave drives rdy.
// -----------------------------------------------------------------------------
package ingress_rdreq_pkg;
   localparam int PCIE_DATA_WIDTH = 256;

   typedef struct packed {
      logic [63:0] address;
      logic [9:0]  length;
      logic [15:0] req_id;
      logic [7:0]  tag;
      logic [2:0]  tc;
      logic [1:0]  attr;
   } tlp_head_t;
endpackage

interface rdreq_in_if #(
   parameter int DATA_W = ingress_rdreq_pkg::PCIE_DATA_WIDTH
);
   logic [DATA_W-1:0]          rdreq_data;
   logic [DATA_W/32-1:0]       rdreq_keep;
   ingress_rdreq_pkg::tlp_head_t rdreq_meta;
   logic                       rdreq_valid;
   logic                       rdreq_rdy;

   modport master (output rdreq_data, rdreq_keep, rdreq_meta, rdreq_valid,
                   input  rdreq_rdy);
   modport slave  (input  rdreq_data, rdreq_keep, rdreq_meta, rdreq_valid,
                   output rdreq_rdy);
endinterface

interface rd_req_out_if #(
   parameter int CHNL_W = 4
);
   logic                rd_req_valid;
   logic                rd_req_rdy;
   logic [5+CHNL_W-1:0] rd_tdest;
   logic [35:0]         rd_cpl_ctx;
   logic                rd_err;

   modport master (output rd_req_valid, rd_tdest, rd_cpl_ctx, rd_err,
                   input  rd_req_rdy);
   modport slave  (input  rd_req_valid, rd_tdest, rd_cpl_ctx, rd_err,
                   output rd_req_rdy);
endinterface

// File: rtl/ingress_rdreq_dispatch.sv
// -----------------------------------------------------------------------------
// ingress_rdreq_dispatch
//
// Decodes memory-read TLP headers into a {reg, action, channel} destination,
// stores decode + completion context in a small FIFO and presents the FIFO
// head on a valid/ready stream. Outstanding reads are capped by a credit
// counter. Malformed reads are flagged (rd_err) rather than dropped so every
// read still gets a completion.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   rdreq         : rdreq_in_if.slave   - header stream in
//   rd_req        : rd_req_out_if.master - decoded request stream out
//   rd_done       : one-cycle pulse per completion sent (returns a credit)
//   inflight      : accepted-but-not-completed read count
//   err_underflow : sticky, rd_done seen with inflight == 0
// -----------------------------------------------------------------------------
module ingress_rdreq_dispatch
   import ingress_rdreq_pkg::*;
#(
   parameter int CHNL_W     = 4,
   parameter int CHNL_NUM   = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_OUT    = 8,
   parameter int DATA_W     = PCIE_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   rdreq_in_if.slave                    rdreq,
   rd_req_out_if.master                 rd_req,
   input  logic                         rd_done,
   output logic [$clog2(MAX_OUT+1)-1:0] inflight,
   output logic                         err_underflow
);
   localparam int TDEST_W = 5 + CHNL_W;
   localparam int CTX_W   = 16 + 8 + 7 + 3 + 2;
   localparam int ENTRY_W = 1 + TDEST_W + CTX_W;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int INF_W   = $clog2(MAX_OUT + 1);

   tlp_head_t            meta;
   logic [3:0]           offset;
   logic [CHNL_W-1:0]    chan;
   logic [2:0]           dec_reg;
   logic [1:0]           dec_action;
   logic                 dec_known;
   logic                 dec_global;
   logic                 dec_err;
   logic [TDEST_W-1:0]   dec_tdest;
   logic [CTX_W-1:0]     dec_ctx;
   logic [ENTRY_W-1:0]   entry_in;

   logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [CNT_W-1:0]     count_reg;
   logic [CNT_W-1:0]     count_next;
   logic                 out_valid_reg;
   logic [ENTRY_W-1:0]   out_entry_reg;
   logic                 ready_en_reg;
   logic [INF_W-1:0]     inflight_reg;
   logic [INF_W-1:0]     inflight_next;
   logic                 underflow_reg;
   logic                 underflow_next;
   logic                 push;
   logic                 pop;
   logic                 load;

   // Header-only requests: payload and the address bits outside [6+CHNL_W-1:2]
   // carry no information for this block.
   logic [DATA_W-1:0]    data_unused;
   logic [DATA_W/32-1:0] keep_unused;
   logic                 addr_unused;
   assign data_unused = rdreq.rdreq_data;
   assign keep_unused = rdreq.rdreq_keep;
   assign addr_unused = ^{meta.address[63:6+CHNL_W], meta.address[1:0]};

   assign meta   = rdreq.rdreq_meta;
   assign offset = meta.address[5:2];
   assign chan   = meta.address[6 +: CHNL_W];

   // ---------------------------------------------------------------- decode
   always_comb begin
      dec_known  = 1'b1;
      dec_global = 1'b0;
      dec_action = 2'b00;
      dec_reg    = 3'b000;
      unique case (offset)
         4'b1000: begin dec_action = 2'b00; dec_reg = 3'b000; end
         4'b1001: begin dec_action = 2'b00; dec_reg = 3'b001; end
         4'b1110: begin dec_action = 2'b00; dec_reg = 3'b010; end
         4'b1101: begin dec_action = 2'b01; dec_reg = 3'b010; end
         4'b1010: begin dec_action = 2'b10; dec_reg = 3'b000; dec_global = 1'b1; end
         4'b1011: begin dec_action = 2'b10; dec_reg = 3'b001; dec_global = 1'b1; end
         4'b1100: begin dec_action = 2'b10; dec_reg = 3'b010; dec_global = 1'b1; end
         4'b1111: begin dec_action = 2'b10; dec_reg = 3'b011; dec_global = 1'b1; end
         default: dec_known = 1'b0;   // 0000-0111 are write-only registers
      endcase

      // Global registers ignore the channel field, so only per-channel
      // registers are range-checked.
      dec_err = !dec_known
              || (!dec_global && (32'(chan) >= CHNL_NUM))
              || (meta.length != 10'd1);

      if (dec_err) begin
         dec_tdest = {3'b111, 2'b11, {CHNL_W{1'b0}}};
      end else begin
         dec_tdest = {dec_reg, dec_action, dec_global ? {CHNL_W{1'b0}} : chan};
      end
   end

   assign dec_ctx  = {meta.req_id, meta.tag, meta.address[6:2], 2'b00, meta.tc, meta.attr};
   assign entry_in = {dec_err, dec_tdest, dec_ctx};

   // ------------------------------------------------------------ handshakes
   // Readiness depends only on registered state; the consumer's ready never
   // reaches rdreq_rdy combinationally.
   assign rdreq.rdreq_rdy = ready_en_reg
                          && (count_reg < CNT_W'(FIFO_DEPTH))
                          && (inflight_reg < INF_W'(MAX_OUT));
   assign push = rdreq.rdreq_valid && rdreq.rdreq_rdy;
   assign pop  = out_valid_reg && rd_req.rd_req_rdy;

   // count_reg includes the entry sitting in the output register, so the
   // total number of queued requests never exceeds FIFO_DEPTH. Entries still
   // in the array = count_reg - out_valid_reg; the head register reloads from
   // the array whenever it is empty or being popped.
   assign load = (count_reg > CNT_W'(out_valid_reg)) && (!out_valid_reg || rd_req.rd_req_rdy);

   always_comb begin
      count_next = count_reg;
      unique case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_comb begin
      inflight_next  = inflight_reg;
      underflow_next = underflow_reg;
      unique case ({push, rd_done})
         2'b10: inflight_next = inflight_reg + 1'b1;
         2'b01: begin
            if (inflight_reg == '0) underflow_next = 1'b1;
            else                    inflight_next  = inflight_reg - 1'b1;
         end
         2'b11: begin
            if (inflight_reg == '0) underflow_next = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------- FIFO storage
   // No reset on the array: contents are only meaningful below count_reg.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= entry_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_reg  <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_entry_reg <= '0;
         inflight_reg  <= '0;
         underflow_reg <= 1'b0;
      end else begin
         ready_en_reg  <= 1'b1;
         count_reg     <= count_next;
         inflight_reg  <= inflight_next;
         underflow_reg <= underflow_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (load) begin
            out_valid_reg <= 1'b1;
            out_entry_reg <= mem[rd_ptr_reg];
            rd_ptr_reg    <= rd_ptr_reg + 1'b1;
         end else if (pop) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign rd_req.rd_req_valid = out_valid_reg;
   assign rd_req.rd_err       = out_entry_reg[ENTRY_W-1];
   assign rd_req.rd_tdest     = out_entry_reg[CTX_W +: TDEST_W];
   assign rd_req.rd_cpl_ctx   = out_entry_reg[CTX_W-1:0];
   assign inflight            = inflight_reg;
   assign err_underflow       = underflow_reg;

endmodule

// File: tb/tb_ingress_rdreq_dispatch.sv
`timescale 1ns/1ps
module tb_ingress_rdreq_dispatch;
   import ingress_rdreq_pkg::*;

   localparam int CHNL_W     = 4;
   localparam int CHNL_NUM   = 12;
   localparam int FIFO_DEPTH = 4;
   localparam int MAX_OUT    = 8;
   localparam int DATA_W     = 256;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rd_done = 1'b0;
   logic [3:0] inflight;
   logic       err_underflow;

   rdreq_in_if   #(.DATA_W(DATA_W)) in_if ();
   rd_req_out_if #(.CHNL_W(CHNL_W)) out_if ();

   ingress_rdreq_dispatch #(
      .CHNL_W(CHNL_W), .CHNL_NUM(CHNL_NUM), .FIFO_DEPTH(FIFO_DEPTH),
      .MAX_OUT(MAX_OUT), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rdreq(in_if), .rd_req(out_if),
      .rd_done(rd_done), .inflight(inflight), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------ model state
   typedef struct {
      logic [8:0]  tdest;
      logic [35:0] ctx;
      logic        err;
      int          acc_edge;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_bad = 0;
   int   edge_cnt = 0, since_rel = 0;
   int   m_infl = 0;
   bit   m_uflow = 0;
   int   acc_total = 0, pop_total = 0;
   int   auto_acked = 0;
   bit   auto_done = 0, force_done = 0;

   // Register map by offset: action (-1 = write-only) and register number.
   int act_tab[16] = '{-1, -1, -1, -1, -1, -1, -1, -1, 0, 0, 2, 2, 2, 1, 0, 2};
   int reg_tab[16] = '{ 0,  0,  0,  0,  0,  0,  0,  0, 0, 1, 0, 1, 2, 2, 2, 3};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_entry(input tlp_head_t m);
      exp_t   e;
      int     off, ch, act, rg, t;
      bit     bad;
      longint c;
      off = int'(m.address[5:2]);
      ch  = int'(m.address[9:6]);
      act = act_tab[off];
      rg  = reg_tab[off];
      bad = (act < 0) || (m.length != 10'd1) || (act != 2 && ch >= CHNL_NUM);
      if (bad) t = 'h1F0;
      else     t = rg * 64 + act * 16 + ((act == 2) ? 0 : ch);
      c = (longint'(m.req_id) << 20) | (longint'(m.tag) << 12)
        | (longint'(m.address[6:2]) << 7) | (longint'(m.tc) << 2) | longint'(m.attr);
      e.tdest    = 9'(t);
      e.ctx      = 36'(c);
      e.err      = bad;
      e.acc_edge = 0;
      return e;
   endfunction

   // ------------------------------------------------ per-cycle compare/model
   // Runs at the falling edge: checks current outputs, then advances the model
   // by what the coming rising edge will do.
   always @(negedge clk) begin : mon
      bit   exp_rdy, exp_vld, acc, pop;
      exp_t e;
      if (!rst_n) begin
         q.delete();
         m_infl    = 0;
         m_uflow   = 0;
         since_rel = 0;
         chk("rst_rdreq_rdy", in_if.rdreq_rdy, 0);
         chk("rst_valid", out_if.rd_req_valid, 0);
         chk("rst_tdest", out_if.rd_tdest, 0);
         chk("rst_ctx", out_if.rd_cpl_ctx, 0);
         chk("rst_err", out_if.rd_err, 0);
         chk("rst_inflight", inflight, 0);
         chk("rst_underflow", err_underflow, 0);
      end else begin
         exp_rdy = (since_rel >= 1) && (q.size() < FIFO_DEPTH) && (m_infl < MAX_OUT);
         exp_vld = (q.size() > 0) && (q[0].acc_edge < edge_cnt);
         chk("rdreq_rdy", in_if.rdreq_rdy, exp_rdy);
         chk("rd_req_valid", out_if.rd_req_valid, exp_vld);
         if (exp_vld) begin
            chk("rd_tdest", out_if.rd_tdest, q[0].tdest);
            chk("rd_cpl_ctx", out_if.rd_cpl_ctx, q[0].ctx);
            chk("rd_err", out_if.rd_err, q[0].err);
         end
         chk("inflight", inflight, m_infl);
         chk("err_underflow", err_underflow, m_uflow);

         acc = in_if.rdreq_valid && exp_rdy;
         pop = exp_vld && out_if.rd_req_rdy;
         if (pop) begin
            void'(q.pop_front());
            pop_total++;
         end
         if (acc) begin
            e = model_entry(in_if.rdreq_meta);
            e.acc_edge = edge_cnt + 1;
            q.push_back(e);
            acc_total++;
         end
         if (rd_done) begin
            if (m_infl == 0) m_uflow = 1;
            else if (!acc)   m_infl--;
         end else if (acc) begin
            m_infl++;
         end
         since_rel++;
      end
      edge_cnt++;
   end

   // Completion side: forced pulses for directed tests, otherwise one pulse
   // per dispatched request with a random delay.
   always begin
      @(posedge clk);
      #2;
      if (!rst_n)
         rd_done = 1'b0;
      else if (force_done)
         rd_done = 1'b1;
      else if (auto_done && (pop_total > auto_acked) && ($urandom_range(0, 1) == 1)) begin
         rd_done = 1'b1;
         auto_acked++;
      end else
         rd_done = 1'b0;
   end

   // ----------------------------------------------------------------- helpers
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_hdr(input logic [7:0] a, input logic [9:0] len);
      tlp_head_t h;
      h.address       = {$urandom, $urandom};
      h.address[9:2]  = a;
      h.length        = len;
      h.req_id        = 16'($urandom);
      h.tag           = 8'($urandom);
      h.tc            = 3'($urandom);
      h.attr          = 2'($urandom);
      in_if.rdreq_meta = h;
      in_if.rdreq_data = {8{$urandom}};
      in_if.rdreq_keep = 8'($urandom);
   endtask

   task automatic send(input logic [7:0] a, input logic [9:0] len);
      int a0, n;
      a0 = acc_total;
      n  = 0;
      set_hdr(a, len);
      in_if.rdreq_valid = 1'b1;
      do begin
         cyc();
         n++;
      end while (acc_total == a0 && n < 100);
      in_if.rdreq_valid = 1'b0;
      if (acc_total == a0) chk("send_timeout", 1, 0);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((m_infl != 0 || q.size() != 0) && n < 300) begin
         cyc();
         n++;
      end
      chk(name, (n < 300), 1);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int a0, k, p0;
      in_if.rdreq_valid = 1'b0;
      set_hdr(8'h00, 10'd1);
      out_if.rd_req_rdy = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      cyc();

      // Single read: ch 3, offset 1000
      out_if.rd_req_rdy = 1'b1;
      send(8'b0011_1000, 10'd1);
      cyc();
      chk("t1_valid", out_if.rd_req_valid, 1);
      chk("t1_tdest", out_if.rd_tdest, 9'b000_00_0011);
      chk("t1_err", out_if.rd_err, 0);
      chk("t1_lower_addr", out_if.rd_cpl_ctx[11:5], 7'h60);
      chk("t1_inflight", inflight, 1);
      auto_done = 1'b1;
      wait_idle("t1_idle");

      // Decode sweep: all offsets x channels 0, 11, 12; then bad lengths
      for (int off = 0; off < 16; off++) begin
         send({4'd0, 4'(off)}, 10'd1);
         send({4'd11, 4'(off)}, 10'd1);
         send({4'd12, 4'(off)}, 10'd1);
      end
      send(8'h38, 10'd2);
      send(8'h38, 10'd0);
      send(8'hAA, 10'd1);
      wait_idle("sweep_idle");

      // Backpressure: consumer stalled, 5 back-to-back headers
      out_if.rd_req_rdy = 1'b0;
      a0 = acc_total;
      p0 = pop_total;
      k  = 0;
      for (int c = 0; c < 8; c++) begin
         if (k < 5) begin
            set_hdr({4'(k), 4'b1000}, 10'd1);
            in_if.rdreq_valid = 1'b1;
         end else begin
            in_if.rdreq_valid = 1'b0;
         end
         cyc();
         if (acc_total - a0 > k) k++;
      end
      in_if.rdreq_valid = 1'b0;
      chk("bp_accepted", acc_total - a0, 4);
      chk("bp_rdreq_rdy", in_if.rdreq_rdy, 0);
      out_if.rd_req_rdy = 1'b1;
      repeat (8) cyc();
      chk("bp_popped", pop_total - p0, 4);
      chk("bp_drained", out_if.rd_req_valid, 0);
      wait_idle("bp_idle");

      // Credit limit: no completions until 20 cycles of offered headers
      auto_done = 1'b0;
      a0 = acc_total;
      for (int c = 0; c < 20; c++) begin
         set_hdr(8'($urandom), 10'd1);
         in_if.rdreq_valid = 1'b1;
         cyc();
      end
      chk("cr_accepted", acc_total - a0, 8);
      chk("cr_rdreq_rdy", in_if.rdreq_rdy, 0);
      chk("cr_inflight", inflight, 8);
      force_done = 1'b1;
      cyc();
      force_done = 1'b0;
      auto_acked++;
      for (int c = 0; c < 10; c++) begin
         set_hdr(8'($urandom), 10'd1);
         cyc();
      end
      in_if.rdreq_valid = 1'b0;
      chk("cr_one_more", acc_total - a0, 9);
      auto_done = 1'b1;
      wait_idle("cr_idle");

      // Simultaneous accept and completion at inflight 5
      auto_done = 1'b0;
      repeat (5) send(8'h38, 10'd1);
      repeat (3) cyc();
      chk("sim_pre_inflight", inflight, 5);
      a0 = acc_total;
      set_hdr(8'h39, 10'd1);
      in_if.rdreq_valid = 1'b1;
      force_done = 1'b1;
      cyc();
      in_if.rdreq_valid = 1'b0;
      force_done = 1'b0;
      auto_acked++;
      chk("sim_accepted", acc_total - a0, 1);
      chk("sim_inflight", inflight, 5);
      auto_done = 1'b1;
      wait_idle("sim_idle");
      auto_done = 1'b0;
      repeat (3) cyc();
      chk("uf_pre_inflight", inflight, 0);
      force_done = 1'b1;
      cyc();
      force_done = 1'b0;
      cyc();
      chk("uf_flag", err_underflow, 1);
      chk("uf_inflight", inflight, 0);

      // Reset with 3 requests queued
      out_if.rd_req_rdy = 1'b0;
      repeat (3) send(8'hE5, 10'd1);
      cyc();
      chk("rs_pre_valid", out_if.rd_req_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rs_valid", out_if.rd_req_valid, 0);
      chk("rs_tdest", out_if.rd_tdest, 0);
      chk("rs_ctx", out_if.rd_cpl_ctx, 0);
      chk("rs_inflight", inflight, 0);
      chk("rs_underflow", err_underflow, 0);
      chk("rs_rdreq_rdy", in_if.rdreq_rdy, 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      auto_acked = pop_total;
      cyc();
      cyc();
      chk("rs_post_rdy", in_if.rdreq_rdy, 1);
      chk("rs_post_valid", out_if.rd_req_valid, 0);
      chk("rs_post_inflight", inflight, 0);
      out_if.rd_req_rdy = 1'b1;
      send(8'b1011_1001, 10'd1);
      cyc();
      chk("rs_new_valid", out_if.rd_req_valid, 1);
      chk("rs_new_tdest", out_if.rd_tdest, 9'b001_00_1011);
      auto_done = 1'b1;
      wait_idle("rs_idle");

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         set_hdr(8'($urandom), ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'd1);
         in_if.rdreq_valid = ($urandom_range(0, 2) != 0);
         out_if.rd_req_rdy = ($urandom_range(0, 3) != 0);
         cyc();
      end
      in_if.rdreq_valid = 1'b0;
      out_if.rd_req_rdy = 1'b1;
      wait_idle("rand_idle");
      repeat (3) cyc();
      chk("final_valid", out_if.rd_req_valid, 0);
      chk("final_inflight", inflight, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
